// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART transmit queue.
package uart_pkg;

  localparam int unsigned ByteWidth          = 8;
  localparam int unsigned DefaultDepth       = 16;
  localparam int unsigned DefaultBusyTimeout = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitBusy,
    StWaitDone
  } tx_queue_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous single-clock FIFO with first-word-fall-through head.
// A write while full is dropped and flagged on o_overflow one cycle later.
module uart_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned Depth  = DefaultDepth,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned LevelW = PtrW + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_valid,
  input  logic [ByteWidth-1:0] i_wr_data,
  output logic                 o_wr_ready,
  input  logic                 i_rd_pop,
  output logic [ByteWidth-1:0] o_rd_data,
  output logic [LevelW-1:0]    o_level,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_overflow
);

  logic [ByteWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0]    count_q, count_d;
  logic                 overflow_q;
  logic                 push, pop, drop;

  assign o_full     = (count_q == LevelW'(Depth));
  assign o_empty    = (count_q == '0);
  assign o_wr_ready = ~o_full;
  assign o_level    = count_q;
  assign o_rd_data  = mem_q[rd_ptr_q];
  assign o_overflow = overflow_q;

  // A pop on the same cycle never frees room for a write that arrived while full.
  assign push = i_wr_valid & ~o_full;
  assign drop = i_wr_valid & o_full;
  assign pop  = i_rd_pop & ~o_empty;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + LevelW'(1);
      2'b01:   count_d = count_q - LevelW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q    <= count_d;
      overflow_q <= drop;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_wr_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a uart_tx: pops one byte per launch and tracks the busy handshake.
// Define UART_TX_QUEUE_STATS_EN to add drop-count and high-water-mark outputs.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter  int unsigned Depth       = DefaultDepth,
  parameter  int unsigned BusyTimeout = DefaultBusyTimeout,
  localparam int unsigned LevelW      = $clog2(Depth) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_valid,
  input  logic [ByteWidth-1:0] i_wr_byte,
  output logic                 o_wr_ready,
  output logic                 o_tx_enable,
  output logic [ByteWidth-1:0] o_tx_data,
  input  logic                 i_tx_busy,
  output logic [LevelW-1:0]    o_level,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_overflow
`ifdef UART_TX_QUEUE_STATS_EN
  ,
  output logic [15:0]          o_drop_count,
  output logic [LevelW-1:0]    o_max_level
`endif
);

  localparam int unsigned TimerW = $clog2(BusyTimeout + 1);

  tx_queue_state_t      state_q, state_d;
  logic [TimerW-1:0]    timer_q;
  logic [ByteWidth-1:0] tx_data_q;
  logic [ByteWidth-1:0] head_byte;
  logic                 fifo_pop;
  logic                 timeout;

  uart_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_valid (i_wr_valid),
    .i_wr_data  (i_wr_byte),
    .o_wr_ready (o_wr_ready),
    .i_rd_pop   (fifo_pop),
    .o_rd_data  (head_byte),
    .o_level    (o_level),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_overflow (o_overflow)
  );

  assign timeout = (timer_q == TimerW'(BusyTimeout - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (!o_empty && !i_tx_busy) state_d = StLaunch;
      StLaunch:   state_d = StWaitBusy;
      StWaitBusy: begin
        if (i_tx_busy)    state_d = StWaitDone;
        else if (timeout) state_d = StIdle;
      end
      StWaitDone: if (!i_tx_busy) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    o_tx_enable = (state_q == StLaunch);
    fifo_pop    = (state_q == StIdle) && !o_empty && !i_tx_busy;
  end

  // A missing busy response is treated as a completed send after BusyTimeout cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst || state_q != StWaitBusy) timer_q <= '0;
    else                                timer_q <= timer_q + TimerW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)         tx_data_q <= '0;
    else if (fifo_pop) tx_data_q <= head_byte;
  end

  assign o_tx_data = tx_data_q;

`ifdef UART_TX_QUEUE_STATS_EN
  logic [15:0]       drop_count_q;
  logic [LevelW-1:0] max_level_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_count_q <= '0;
      max_level_q  <= '0;
    end else begin
      if (i_wr_valid && o_full && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
      if (o_level > max_level_q) max_level_q <= o_level;
    end
  end

  assign o_drop_count = drop_count_q;
  assign o_max_level  = max_level_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: stimulus pushes expected bytes, a monitor
// checks every launch and plays the uart_tx busy response.
module tb_uart_tx_queue;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned LEVEL_W = 5;

  logic               clk;
  logic               rst;
  logic               wr_valid;
  logic [7:0]         wr_byte;
  logic               wr_ready;
  logic               tx_enable;
  logic [7:0]         tx_data;
  logic               tx_busy;
  logic [LEVEL_W-1:0] level;
  logic               empty;
  logic               full;
  logic               overflow;
`ifdef UART_TX_QUEUE_STATS_EN
  logic [15:0]        drop_count;
  logic [LEVEL_W-1:0] max_level;
`endif

  uart_tx_queue #(
    .Depth       (DEPTH),
    .BusyTimeout (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_valid  (wr_valid),
    .i_wr_byte   (wr_byte),
    .o_wr_ready  (wr_ready),
    .o_tx_enable (tx_enable),
    .o_tx_data   (tx_data),
    .i_tx_busy   (tx_busy),
    .o_level     (level),
    .o_empty     (empty),
    .o_full      (full),
    .o_overflow  (overflow)
`ifdef UART_TX_QUEUE_STATS_EN
    ,
    .o_drop_count (drop_count),
    .o_max_level  (max_level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] exp_q[$];
  int accepted = 0;
  int launches = 0;
  int mcount   = 0;
  int drops    = 0;
  int peak     = 0;
  int hw_prev  = 0;

  // Busy responder controls
  bit hold_busy = 0;
  int force_dur = -1;

  // Issue one cycle of stimulus from a negedge, then check at the next negedge.
  task automatic step(input bit v, input logic [7:0] b);
    bit accept;
    wr_valid = v;
    wr_byte  = b;
    accept   = v && (mcount < int'(DEPTH));
    if (accept) begin
      exp_q.push_back(b);
      accepted++;
    end else if (v) begin
      drops++;
    end
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    if (tx_enable) launches++;
    mcount = accepted - launches;
    check("overflow", overflow, v && !accept);
    check("level", level, mcount);
    check("empty", empty, mcount == 0);
    check("full", full, mcount == int'(DEPTH));
    check("wr_ready", wr_ready, mcount < int'(DEPTH));
`ifdef UART_TX_QUEUE_STATS_EN
    check("drop_count", drop_count, (drops > 65535) ? 65535 : drops);
    check("max_level", max_level, hw_prev);
`endif
    if (mcount > hw_prev) hw_prev = mcount;
    if (mcount > peak) peak = mcount;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wr_valid = 1'b0;
    exp_q.delete();
    accepted = 0;
    launches = 0;
    mcount   = 0;
    drops    = 0;
    hw_prev  = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_tx_enable", tx_enable, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_overflow", overflow, 0);
`ifdef UART_TX_QUEUE_STATS_EN
    check("rst_drop_count", drop_count, 0);
    check("rst_max_level", max_level, 0);
`endif
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      step(1'b0, 8'h00);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: compares launches against the scoreboard and drives the busy response.
  logic [7:0] exp_data  = 8'h00;
  logic [7:0] got;
  int  ncyc      = 0;
  int  busy_left = 0;
  int  last_cyc  = 0;
  int  min_gap   = 0;
  int  dur       = 0;
  bit  have_prev = 0;
  bit  exact     = 0;

  initial tx_busy = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (busy_left > 0) busy_left--;
    if (rst) begin
      exp_data  = 8'h00;
      have_prev = 0;
    end else if (tx_enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_launch actual=%0h required=none", tx_data);
      end else begin
        got = exp_q.pop_front();
        check("launch_data", tx_data, got);
        exp_data = got;
      end
      if (have_prev) begin
        if (exact) begin
          check("launch_gap", ncyc - last_cyc, min_gap);
        end else begin
          checks++;
          if (ncyc - last_cyc < min_gap) begin
            errors++;
            $display("FAIL launch_gap_min actual=%0d required>=%0d", ncyc - last_cyc, min_gap);
          end
        end
      end
      if (force_dur >= 0) dur = force_dur;
      else if ($urandom_range(0, 4) == 0) dur = 0;
      else dur = int'($urandom_range(2, 12));
      busy_left = dur;
      // Busy seen for dur edges: WAIT_DONE exits after dur edges; no busy means timeout.
      min_gap   = (dur == 0) ? (TIMEOUT + 2) : (dur + 2);
      exact     = (exp_q.size() > 0);
      last_cyc  = ncyc;
      have_prev = 1;
    end else begin
      check("tx_data_stable", tx_data, exp_data);
    end
    if (hold_busy) have_prev = 0;
    tx_busy = hold_busy || (busy_left > 0);
  end

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_byte  = 8'h00;
    @(negedge clk);
    do_reset();

    // Single byte, then a second byte to time the return to IDLE after busy falls
    force_dur = 10;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h11);
    check("launch_latency", tx_enable, 1);
    check("single_data", tx_data, 8'hA5);
    repeat (30) step(1'b0, 8'h00);

    // Burst 01..05
    force_dur = 3;
    peak = 0;
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i));
    check("burst_peak", (peak == 4 || peak == 5), 1);
    drain("burst_drain", 100);

    // Overflow with busy held high
    repeat (15) step(1'b0, 8'h00);
    hold_busy = 1;
    repeat (2) step(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom));
    check("full_after_16", full, 1);
    step(1'b1, 8'hEE);
    check("overflow_pulse", overflow, 1);
    step(1'b0, 8'h00);
    check("overflow_once", overflow, 0);
    check("blocked_by_busy", level, DEPTH);
    hold_busy = 0;
    force_dur = -1;
    drain("overflow_drain", 600);

    // Timeout: no busy response, second byte times the timeout return
    repeat (15) step(1'b0, 8'h00);
    force_dur = 0;
    step(1'b1, 8'h3C);
    step(1'b1, 8'h5A);
    check("timeout_launch", tx_enable, 1);
    check("timeout_data", tx_data, 8'h3C);
    repeat (15) step(1'b0, 8'h00);
    check("timeout_drained", exp_q.size(), 0);

    // Reset while in WAIT_DONE with three bytes still queued
    force_dur = 30;
    for (int i = 0; i < 4; i++) step(1'b1, 8'h80 + 8'(i));
    repeat (2) step(1'b0, 8'h00);
    check("pre_reset_level", level, 3);
    do_reset();
    repeat (40) step(1'b0, 8'h00);

    // Random stream with random busy durations
    force_dur = -1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, 8'h00);
      step(1'b1, 8'($urandom));
    end
    drain("random_drain", 2000);
    repeat (20) step(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameters SHALL be:
  Depth, 16, FIFO entries; power of two, 2..256.
  BusyTimeout, 4, cycles to wait for i_tx_busy after a launch.
REQ-002 Ports SHALL be:
  i_clk  in  1  single clock, all logic on posedge.
  i_rst  in  1  reset, synchronous and active-high.
  i_wr_valid  in  1  byte offered (e.g. from uart_rx o_rx_valid).
  i_wr_byte  in  8  offered byte.
  o_wr_ready  out  1  high when not full.
  o_tx_enable  out  1  one-cycle launch pulse to uart_tx.
  o_tx_data  out  8  byte for uart_tx.
  i_tx_busy  in  1  uart_tx busy flag.
  o_level  out  $clog2(Depth)+1  current occupancy.
  o_empty  out  1  occupancy == 0.
  o_full  out  1  occupancy == Depth.
  o_overflow  out  1  one-cycle pulse, byte dropped.

Function
REQ-003 Push SHALL occur on a cycle with i_wr_valid=1 and o_full=0; o_level SHALL reflect it after that edge.
REQ-004 i_wr_valid=1 while o_full=1 SHALL drop the byte, leave the FIFO unchanged and pulse o_overflow next cycle, even if a pop occurs on the same cycle.
REQ-005 A push and a pop on the same cycle SHALL leave o_level unchanged; pointers SHALL wrap modulo Depth.
REQ-006 The FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-007 IDLE -> LAUNCH SHALL occur when o_empty=0 and i_tx_busy=0; the head byte SHALL be popped on that edge into o_tx_data.
REQ-008 In LAUNCH, o_tx_enable SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT_BUSY.
REQ-009 WAIT_BUSY -> WAIT_DONE SHALL occur on i_tx_busy=1.
REQ-010 WAIT_BUSY -> IDLE SHALL occur after BusyTimeout cycles without busy; the byte SHALL count as sent.
REQ-011 WAIT_DONE -> IDLE SHALL occur on i_tx_busy=0.
REQ-012 o_tx_data SHALL stay stable from LAUNCH until the FSM returns to IDLE.
REQ-013 A byte pushed into an empty queue at edge N, with i_tx_busy=0, SHALL produce o_tx_enable=1 in the cycle after edge N+1.
REQ-014 i_tx_busy already high in IDLE SHALL block a launch until it falls.

Reset
REQ-015 With i_rst=1 at an edge, all of the following SHALL hold after that edge:
  - FSM in IDLE and pointers cleared;
  - o_level=0, o_empty=1, o_full=0, o_wr_ready=1;
  - o_tx_enable=0, o_tx_data=8'h00, o_overflow=0.
REQ-016 Reset mid-transfer SHALL discard all queued bytes and any launch in progress; the FSM SHALL ignore i_tx_busy until it returns to IDLE.

Configuration
REQ-017 With macro UART_TX_QUEUE_STATS_EN defined, the block SHALL add two outputs, both cleared by reset:
  - o_drop_count (16 bits): counts REQ-004 drops and saturates at 16'hFFFF;
  - o_max_level ($clog2(Depth)+1 bits): records the high-water mark of o_level.
REQ-018 Without UART_TX_QUEUE_STATS_EN, those ports and their registers SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-019 Package uart_pkg SHALL hold:
  - the FSM state typedef (tx_queue_state_t);
  - ByteWidth=8;
  - the default Depth and BusyTimeout constants.
REQ-020 Storage and pointers SHALL live in sub-module uart_fifo (synchronous, single clock, first-word-fall-through head); the FSM SHALL live in uart_tx_queue.

Verification
REQ-021 Single byte:
  - Stimulus: push 8'hA5 into the empty queue; model busy rising 1 cycle after launch and holding 10 cycles.
  - Response: one o_tx_enable pulse with o_tx_data=8'hA5; FSM back in IDLE 1 cycle after busy falls.
REQ-022 Burst:
  - Stimulus: push 8'h01..8'h05 on consecutive cycles.
  - Response: five launches in order 01..05, each only after the previous busy falls; o_level peaks at 4 or 5.
REQ-023 Overflow:
  - Stimulus: with busy held high, push 17 bytes into Depth=16.
  - Response: o_full=1; the 17th byte gives one o_overflow pulse; o_drop_count=1 with the macro defined.
REQ-024 Timeout:
  - Stimulus: push 8'h3C and keep busy low.
  - Response: one launch, return to IDLE after 4 cycles, no second launch of 8'h3C.
REQ-025 Reset mid-transfer:
  - Stimulus: assert i_rst during WAIT_DONE with 3 bytes queued.
  - Response: o_level=0 and o_tx_enable=0 after the edge; no further launches.
REQ-026 Wrap and simultaneous push/pop:
  - Stimulus: stream 40 random bytes with random busy durations.
  - Response: output order equals input order; no byte lost while o_wr_ready=1.
